// File: rtl/mac_tx_arb.sv
// mac_tx_arb: frame-granular round-robin arbiter sharing one MAC TX datapath
// between REQ_N upstream requesters. One requester owns the link per frame.
// Its beats pass combinationally to the MAC. A minimum inter-frame gap of
// IFG_CYC idle cycles follows every frame. An aborted frame is drained from
// the granted requester.
//
// Optional feature (macro MAC_TX_ARB_PRIO_EN):
//   defined   - requester 0 has strict priority in IDLE. The other requesters
//               use round-robin among themselves. The pointer moves only on
//               grants to requesters other than 0.
//   undefined - pure round-robin across all requesters.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   cancel_i          abort the frame in flight (honoured in XFER only)
//   req_valid_i/start_i/term_i/data_i/len_i
//                     per-requester beat; requester i uses slice i
//   req_ready_o       per-requester beat accept
//   mac_ready_i       MAC accepts a beat
//   mac_valid_o/start_o/term_o/data_o/len_o
//                     beat to MAC; data fields are zero when not valid
//   mac_cancel_o      one-cycle abort pulse, the cycle after cancel_i
//   gnt_o             one-hot current grant; zero when no grant is held
//   busy_o            arbiter is not in IDLE
//
// State | meaning
// IDLE  | waiting for a start beat; stray beats are flushed
// XFER  | granted requester's beats pass through to the MAC
// DRAIN | frame aborted; granted requester is consumed up to its term beat
// IFG   | enforced inter-frame gap
module mac_tx_arb #(
  parameter int REQ_N   = 2,
  parameter int DATA_W  = 16,
  parameter int IFG_CYC = 3,
  localparam int LEN_W  = $clog2(DATA_W/8+1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cancel_i,
  input  logic [REQ_N-1:0]        req_valid_i,
  input  logic [REQ_N-1:0]        req_start_i,
  input  logic [REQ_N-1:0]        req_term_i,
  input  logic [REQ_N*DATA_W-1:0] req_data_i,
  input  logic [REQ_N*LEN_W-1:0]  req_len_i,
  output logic [REQ_N-1:0]        req_ready_o,
  input  logic                    mac_ready_i,
  output logic                    mac_valid_o,
  output logic                    mac_start_o,
  output logic                    mac_term_o,
  output logic [DATA_W-1:0]       mac_data_o,
  output logic [LEN_W-1:0]        mac_len_o,
  output logic                    mac_cancel_o,
  output logic [REQ_N-1:0]        gnt_o,
  output logic                    busy_o
);

  localparam int GW = (REQ_N > 1) ? $clog2(REQ_N) : 1;
  localparam logic [3:0] IFG_LOAD = (IFG_CYC > 0) ? 4'(IFG_CYC - 1) : 4'd0;

`ifdef MAC_TX_ARB_PRIO_EN
  localparam logic PRIO0 = 1'b1;
`else
  localparam logic PRIO0 = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN, S_IFG} state_t;

  // With no gap configured a finished frame returns straight to IDLE.
  localparam state_t S_END = (IFG_CYC > 0) ? S_IFG : S_IDLE;

  state_t            state_q, state_d;
  logic [REQ_N-1:0]  gnt_q, gnt_d;
  logic [GW-1:0]     gidx_q, gidx_d;
  logic [GW-1:0]     last_q, last_d;
  logic [3:0]        ifg_q, ifg_d;
  logic              cancel_q, cancel_d;

  logic [REQ_N-1:0]  cand;
  logic [GW:0]       pick;
  logic [REQ_N-1:0]  ready_c;
  logic              mv_c;
  logic              sel_valid, sel_start, sel_term;
  logic [DATA_W-1:0] sel_data;
  logic [LEN_W-1:0]  sel_len;
  logic              out_en;

  // First candidate after 'last' modulo REQ_N; MSB of the result flags a hit.
  // skip0 removes requester 0 from the rotation (priority mode).
  function automatic logic [GW:0] rr_pick(input logic [REQ_N-1:0] c,
                                          input logic [GW-1:0]    last,
                                          input logic             skip0);
    logic [GW:0]   r;
    logic [GW-1:0] il;
    int            idx;
    r = '0;
    for (int k = 1; k <= REQ_N; k++) begin
      idx = (int'(last) + k) % REQ_N;
      il  = GW'(idx);
      if (!r[GW] && c[il] && !(skip0 && idx == 0)) r = {1'b1, il};
    end
    return r;
  endfunction

  always_comb begin
    sel_valid = 1'b0;
    sel_start = 1'b0;
    sel_term  = 1'b0;
    sel_data  = '0;
    sel_len   = '0;
    for (int i = 0; i < REQ_N; i++) begin
      if (gidx_q == GW'(i)) begin
        sel_valid = req_valid_i[i];
        sel_start = req_start_i[i];
        sel_term  = req_term_i[i];
        sel_data  = req_data_i[i*DATA_W +: DATA_W];
        sel_len   = req_len_i[i*LEN_W +: LEN_W];
      end
    end
  end

  assign cand = req_valid_i & req_start_i;
  assign pick = rr_pick(cand, last_q, PRIO0);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gidx_d   = gidx_q;
    last_d   = last_q;
    ifg_d    = ifg_q;
    cancel_d = 1'b0;
    ready_c  = '0;
    mv_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_c = req_valid_i & ~req_start_i;
        if (PRIO0 && cand[0]) begin
          state_d = S_XFER;
          gidx_d  = '0;
          gnt_d   = '0;
          gnt_d[0] = 1'b1;
        end else if (pick[GW]) begin
          state_d = S_XFER;
          gidx_d  = pick[GW-1:0];
          last_d  = pick[GW-1:0];
          gnt_d   = '0;
          gnt_d[pick[GW-1:0]] = 1'b1;
        end
      end
      S_XFER: begin
        if (cancel_i) begin
          cancel_d = 1'b1;
          // A term beat in the cancel cycle ends the frame immediately.
          if (sel_valid && sel_term) begin
            ready_c[gidx_q] = 1'b1;
            state_d = S_END;
            gnt_d   = '0;
            ifg_d   = IFG_LOAD;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          mv_c = sel_valid;
          ready_c[gidx_q] = mac_ready_i;
          if (sel_valid && mac_ready_i && sel_term) begin
            state_d = S_END;
            gnt_d   = '0;
            ifg_d   = IFG_LOAD;
          end
        end
      end
      S_DRAIN: begin
        ready_c[gidx_q] = 1'b1;
        if (sel_valid && sel_term) begin
          state_d = S_END;
          gnt_d   = '0;
          ifg_d   = IFG_LOAD;
        end
      end
      S_IFG: begin
        if (ifg_q == 4'd0) state_d = S_IDLE;
        else               ifg_d   = ifg_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      gidx_q   <= '0;
      last_q   <= GW'(REQ_N - 1);
      ifg_q    <= '0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gidx_q   <= gidx_d;
      last_q   <= last_d;
      ifg_q    <= ifg_d;
      cancel_q <= cancel_d;
    end
  end

  // Reset is synchronous, so the flops still hold pre-reset state during the
  // reset cycle. The outputs are masked so the link looks idle immediately.
  assign out_en       = ~reset;
  assign mac_valid_o  = mv_c & out_en;
  assign mac_start_o  = mac_valid_o & sel_start;
  assign mac_term_o   = mac_valid_o & sel_term;
  assign mac_data_o   = mac_valid_o ? sel_data : '0;
  assign mac_len_o    = mac_valid_o ? sel_len  : '0;
  assign req_ready_o  = ready_c & {REQ_N{out_en}};
  assign gnt_o        = gnt_q & {REQ_N{out_en}};
  assign mac_cancel_o = cancel_q & out_en;
  assign busy_o       = (state_q != S_IDLE) & out_en;

endmodule

// File: tb/tb_mac_tx_arb.sv
module tb_mac_tx_arb;
  localparam int REQ_N   = 2;
  localparam int DATA_W  = 16;
  localparam int IFG_CYC = 3;
  localparam int LEN_W   = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    cancel_i;
  logic [REQ_N-1:0]        req_valid_i, req_start_i, req_term_i, req_ready_o;
  logic [REQ_N*DATA_W-1:0] req_data_i;
  logic [REQ_N*LEN_W-1:0]  req_len_i;
  logic                    mac_ready_i, mac_valid_o, mac_start_o, mac_term_o;
  logic [DATA_W-1:0]       mac_data_o;
  logic [LEN_W-1:0]        mac_len_o;
  logic                    mac_cancel_o, busy_o;
  logic [REQ_N-1:0]        gnt_o;

  mac_tx_arb #(.REQ_N(REQ_N), .DATA_W(DATA_W), .IFG_CYC(IFG_CYC)) dut (
    .clk(clk), .reset(reset), .cancel_i(cancel_i),
    .req_valid_i(req_valid_i), .req_start_i(req_start_i), .req_term_i(req_term_i),
    .req_data_i(req_data_i), .req_len_i(req_len_i), .req_ready_o(req_ready_o),
    .mac_ready_i(mac_ready_i), .mac_valid_o(mac_valid_o), .mac_start_o(mac_start_o),
    .mac_term_o(mac_term_o), .mac_data_o(mac_data_o), .mac_len_o(mac_len_o),
    .mac_cancel_o(mac_cancel_o), .gnt_o(gnt_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // {mac_valid, mac_start, mac_term, mac_data, mac_len, req_ready, gnt, mac_cancel, busy}
  logic [26:0] obs;
  assign obs = {mac_valid_o, mac_start_o, mac_term_o, mac_data_o, mac_len_o,
                req_ready_o, gnt_o, mac_cancel_o, busy_o};

  typedef struct {
    logic        cancel;
    logic        mrdy;
    logic [1:0]  v, s, t;
    logic [15:0] d0, d1;
    logic [1:0]  l0, l1;
    logic [26:0] want;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [26:0] ex(input logic mv, ms, mt, input logic [15:0] md,
                                     input logic [1:0] ml, rd, g, input logic mc, bz);
    return {mv, ms, mt, md, ml, rd, g, mc, bz};
  endfunction

  function automatic vec_t mk(input logic c, r, input logic [1:0] v, s, t,
                              input logic [15:0] d0, d1, input logic [1:0] l0, l1,
                              input logic [26:0] w);
    vec_t x;
    x.cancel = c; x.mrdy = r; x.v = v; x.s = s; x.t = t;
    x.d0 = d0; x.d1 = d1; x.l0 = l0; x.l1 = l1; x.want = w;
    return x;
  endfunction

  task automatic drive(input vec_t x);
    cancel_i    = x.cancel;
    mac_ready_i = x.mrdy;
    req_valid_i = x.v;
    req_start_i = x.s;
    req_term_i  = x.t;
    req_data_i  = {x.d1, x.d0};
    req_len_i   = {x.l1, x.l0};
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [26:0] w);
    n_cmp++;
    if (obs !== w) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, obs, w);
    end
  endtask

  logic [26:0] Z, IFGE;
  vec_t        zin;

  initial begin
    Z    = ex(0, 0, 0, 16'h0, 2'd0, 2'b00, 2'b00, 0, 0);
    IFGE = ex(0, 0, 0, 16'h0, 2'd0, 2'b00, 2'b00, 0, 1);
    zin  = mk(0, 1, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 2'd0, 2'd0, Z);

    // both requesters start 4-beat frames; requester 0 first, then the gap
    tbl.push_back(mk(0,1,2'b11,2'b11,2'b00,16'hA000,16'hB000,2,2, Z));
    tbl.push_back(mk(0,1,2'b11,2'b11,2'b00,16'hA000,16'hB000,2,2, ex(1,1,0,16'hA000,2,2'b01,2'b01,0,1)));
    tbl.push_back(mk(0,1,2'b11,2'b10,2'b00,16'hA001,16'hB000,2,2, ex(1,0,0,16'hA001,2,2'b01,2'b01,0,1)));
    tbl.push_back(mk(0,1,2'b11,2'b10,2'b00,16'hA002,16'hB000,2,2, ex(1,0,0,16'hA002,2,2'b01,2'b01,0,1)));
    tbl.push_back(mk(0,1,2'b11,2'b10,2'b01,16'hA003,16'hB000,1,2, ex(1,0,1,16'hA003,1,2'b01,2'b01,0,1)));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,2'b10,2'b10,2'b00,16'h0,16'hB000,0,2, IFGE));
    tbl.push_back(mk(0,1,2'b10,2'b10,2'b00,16'h0,16'hB000,0,2, Z));
    // requester 1 frame under mac_ready toggling
    tbl.push_back(mk(0,1,2'b10,2'b10,2'b00,16'h0,16'hB000,0,2, ex(1,1,0,16'hB000,2,2'b10,2'b10,0,1)));
    tbl.push_back(mk(0,0,2'b10,2'b00,2'b00,16'h0,16'hB001,0,2, ex(1,0,0,16'hB001,2,2'b00,2'b10,0,1)));
    tbl.push_back(mk(0,1,2'b10,2'b00,2'b00,16'h0,16'hB001,0,2, ex(1,0,0,16'hB001,2,2'b10,2'b10,0,1)));
    tbl.push_back(mk(0,0,2'b10,2'b00,2'b00,16'h0,16'hB002,0,2, ex(1,0,0,16'hB002,2,2'b00,2'b10,0,1)));
    tbl.push_back(mk(0,1,2'b10,2'b00,2'b00,16'h0,16'hB002,0,2, ex(1,0,0,16'hB002,2,2'b10,2'b10,0,1)));
    tbl.push_back(mk(0,0,2'b10,2'b00,2'b10,16'h0,16'hB003,0,1, ex(1,0,1,16'hB003,1,2'b00,2'b10,0,1)));
    tbl.push_back(mk(0,1,2'b10,2'b00,2'b10,16'h0,16'hB003,0,1, ex(1,0,1,16'hB003,1,2'b10,2'b10,0,1)));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,2'b00,2'b00,2'b00,16'h0,16'h0,0,0, IFGE));
    // stray beat on requester 1 in IDLE is flushed, never forwarded
    tbl.push_back(mk(0,1,2'b10,2'b00,2'b00,16'h0,16'hDEAD,0,2, ex(0,0,0,16'h0,0,2'b10,2'b00,0,0)));
    tbl.push_back(mk(0,1,2'b00,2'b00,2'b00,16'h0,16'h0,0,0, Z));
    // cancel on beat 2 of a 6-beat frame from requester 0
    tbl.push_back(mk(0,1,2'b01,2'b01,2'b00,16'hC000,16'h0,2,0, Z));
    tbl.push_back(mk(0,1,2'b01,2'b01,2'b00,16'hC000,16'h0,2,0, ex(1,1,0,16'hC000,2,2'b01,2'b01,0,1)));
    tbl.push_back(mk(1,1,2'b01,2'b00,2'b00,16'hC001,16'h0,2,0, ex(0,0,0,16'h0,0,2'b00,2'b01,0,1)));
    tbl.push_back(mk(0,1,2'b01,2'b00,2'b00,16'hC001,16'h0,2,0, ex(0,0,0,16'h0,0,2'b01,2'b01,1,1)));
    tbl.push_back(mk(0,1,2'b01,2'b00,2'b00,16'hC002,16'h0,2,0, ex(0,0,0,16'h0,0,2'b01,2'b01,0,1)));
    tbl.push_back(mk(0,1,2'b01,2'b00,2'b00,16'hC003,16'h0,2,0, ex(0,0,0,16'h0,0,2'b01,2'b01,0,1)));
    tbl.push_back(mk(0,1,2'b01,2'b00,2'b00,16'hC004,16'h0,2,0, ex(0,0,0,16'h0,0,2'b01,2'b01,0,1)));
    tbl.push_back(mk(0,1,2'b01,2'b00,2'b01,16'hC005,16'h0,1,0, ex(0,0,0,16'h0,0,2'b01,2'b01,0,1)));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,2'b00,2'b00,2'b00,16'h0,16'h0,0,0, IFGE));
    // cancel in IDLE is ignored
    tbl.push_back(mk(1,1,2'b00,2'b00,2'b00,16'h0,16'h0,0,0, Z));
    tbl.push_back(mk(0,1,2'b00,2'b00,2'b00,16'h0,16'h0,0,0, Z));

    // reset with a stray beat present: everything must read idle
    reset = 1'b1;
    drive(mk(0,1,2'b10,2'b00,2'b00,16'h0,16'h1234,0,2, Z));
    tick; tick;
    @(negedge clk); chk("reset_hold", Z);
    tick;
    reset = 1'b0;
    drive(zin);
    @(negedge clk); chk("post_reset", Z);
    tick;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("row%0d", i), tbl[i].want);
      tick;
    end

    // reset in the middle of a frame
    drive(mk(0,1,2'b01,2'b01,2'b00,16'hE000,16'h0,2,0, Z));
    tick;
    @(negedge clk); chk("rst_xfer_gnt", ex(1,1,0,16'hE000,2,2'b01,2'b01,0,1));
    tick;
    drive(mk(0,1,2'b01,2'b00,2'b00,16'hE001,16'h0,2,0, Z));
    reset = 1'b1;
    @(negedge clk); chk("rst_midframe", Z);
    tick;
    reset = 1'b0;
    drive(zin);
    @(negedge clk); chk("rst_after", Z);
    tick;
    drive(mk(0,1,2'b11,2'b11,2'b00,16'h1111,16'h2222,2,2, Z));
    @(negedge clk); chk("rst_idle", Z);
    tick;
    @(negedge clk); chk("rst_regrant0", ex(1,1,0,16'h1111,2,2'b01,2'b01,0,1));
    tick;

    // back-to-back single-beat frames from both requesters
    reset = 1'b1;
    drive(zin);
    tick;
    reset = 1'b0;
    drive(mk(0,1,2'b11,2'b11,2'b11,16'hF000,16'hF100,2,2, Z));
    for (int f = 0; f < 4; f++) begin
      logic [1:0]  wg;
      logic [15:0] wd;
      bit          found;
`ifdef MAC_TX_ARB_PRIO_EN
      wg = 2'b01;
`else
      wg = (f % 2 == 0) ? 2'b01 : 2'b10;
`endif
      wd = (wg == 2'b01) ? 16'hF000 : 16'hF100;
      found = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (gnt_o != 2'b00) begin
          found = 1;
          break;
        end
        tick;
      end
      n_cmp++;
      if (!found) begin
        n_err++;
        $display("FAIL prio_frame%0d: no grant within 12 cycles, want gnt %b", f, wg);
      end else if ({gnt_o, mac_data_o, mac_term_o} !== {wg, wd, 1'b1}) begin
        n_err++;
        $display("FAIL prio_frame%0d: got gnt %b data %h term %b want gnt %b data %h term 1",
                 f, gnt_o, mac_data_o, mac_term_o, wg, wd);
      end
      tick;
    end

    // cancel coinciding with the term beat: consumed, straight to gap
    reset = 1'b1;
    drive(zin);
    tick;
    reset = 1'b0;
    drive(mk(0,1,2'b10,2'b10,2'b00,16'h0,16'h9000,0,2, Z));
    tick;
    @(negedge clk); chk("ct_first", ex(1,1,0,16'h9000,2,2'b10,2'b10,0,1));
    tick;
    drive(mk(1,1,2'b10,2'b00,2'b10,16'h0,16'h9001,0,1, Z));
    @(negedge clk); chk("ct_cancel", ex(0,0,0,16'h0,0,2'b10,2'b10,0,1));
    tick;
    drive(zin);
    @(negedge clk); chk("ct_pulse", ex(0,0,0,16'h0,0,2'b00,2'b00,1,1));
    tick;
    @(negedge clk); chk("ct_gap", IFGE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
